// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit.
package bpu_pkg;

    typedef enum logic {
        BPU_IDLE  = 1'b0,
        BPU_FLUSH = 1'b1
    } bpu_state_t;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// Next value of a 2-bit saturating branch counter.
module sat_counter2
    import bpu_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (taken && cnt != CNT_ST)
            nxt = cnt + 2'd1;
        else if (!taken && cnt != CNT_SNT)
            nxt = cnt - 2'd1;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch target adder plus direct-mapped BTB of 2-bit counters.
// Lookup is combinational; invalidation is a one-entry-per-cycle sweep.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int IMM_W     = 16,
    parameter int IMM_SHIFT = 2,
    parameter int PC_INC    = 4,
    parameter int ENTRIES   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    output logic              upd_ready_o,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic [IMM_W-1:0]  upd_imm_i,
    input  logic              upd_taken_i,
    output logic [ADDR_W-1:0] upd_target_o,
    input  logic              flush_i,
    output logic              flush_busy_o
);

    localparam int IDXW  = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDXW;

    bpu_state_t                state;
    logic [IDXW-1:0]           cnt;
    logic [ENTRIES-1:0]        valid;
    logic [2*ENTRIES-1:0]      ctr;
    logic [TAG_W*ENTRIES-1:0]  tags;
    logic [ADDR_W*ENTRIES-1:0] tgts;

    logic [IDXW-1:0]   p_idx, u_idx;
    logic [TAG_W-1:0]  p_tag, u_tag;
    logic              p_hit, u_hit, upd_fire;
    logic [1:0]        u_ctr, u_ctr_nxt;
    logic [ADDR_W-1:0] imm_sx;
    logic              unused_pc;

    assign unused_pc = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

    assign p_idx = pred_pc_i[2 +: IDXW];
    assign p_tag = pred_pc_i[ADDR_W-1 -: TAG_W];
    assign u_idx = upd_pc_i[2 +: IDXW];
    assign u_tag = upd_pc_i[ADDR_W-1 -: TAG_W];

    // Lookups are suppressed while the sweep is only partly done.
    assign p_hit = valid[p_idx]
                && (tags[p_idx*TAG_W +: TAG_W] == p_tag)
                && (state == BPU_IDLE);

    assign pred_hit_o    = p_hit;
    assign pred_taken_o  = p_hit && ctr[2*p_idx+1];
    assign pred_target_o = p_hit ? tgts[p_idx*ADDR_W +: ADDR_W] : '0;

    assign imm_sx = {{(ADDR_W-IMM_W){upd_imm_i[IMM_W-1]}}, upd_imm_i};
    assign upd_target_o = upd_pc_i + ADDR_W'(PC_INC) + (imm_sx << IMM_SHIFT);

    assign u_hit = valid[u_idx] && (tags[u_idx*TAG_W +: TAG_W] == u_tag);
    assign u_ctr = ctr[2*u_idx +: 2];

    assign upd_ready_o  = (state == BPU_IDLE) && !flush_i;
    assign upd_fire     = upd_valid_i && upd_ready_o;
    assign flush_busy_o = (state == BPU_FLUSH);

    sat_counter2 u_sat (
        .cnt   (u_ctr),
        .taken (upd_taken_i),
        .nxt   (u_ctr_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BPU_IDLE;
            cnt   <= '0;
            valid <= '0;
            ctr   <= {ENTRIES{CNT_WNT}};
            tags  <= '0;
            tgts  <= '0;
        end else begin
            unique case (state)
                BPU_IDLE: begin
                    if (flush_i) begin
                        state <= BPU_FLUSH;
                        cnt   <= '0;
                    end else if (upd_fire) begin
                        if (u_hit) begin
                            ctr[2*u_idx +: 2] <= u_ctr_nxt;
                            if (upd_taken_i)
                                tgts[u_idx*ADDR_W +: ADDR_W] <= upd_target_o;
                        end else if (upd_taken_i) begin
                            valid[u_idx]                 <= 1'b1;
                            tags[u_idx*TAG_W +: TAG_W]   <= u_tag;
                            tgts[u_idx*ADDR_W +: ADDR_W] <= upd_target_o;
                            ctr[2*u_idx +: 2]            <= CNT_WT;
                        end
                    end
                end
                BPU_FLUSH: begin
                    valid[cnt] <= 1'b0;
                    if (flush_i)
                        cnt <= '0;
                    else if (cnt == IDXW'(ENTRIES-1))
                        state <= BPU_IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit with directed vectors.
module tb_branch_predict_unit;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    localparam int S_HIT = 0, S_TKN = 1, S_TGT = 2;
    localparam int S_BUSY = 3, S_RDY = 4, S_UTGT = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pred_pc_i;
    logic        pred_hit_o, pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i, upd_ready_o;
    logic [31:0] upd_pc_i;
    logic [15:0] upd_imm_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_o;
    logic        flush_i, flush_busy_o;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    branch_predict_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pred_pc_i     (pred_pc_i),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_ready_o   (upd_ready_o),
        .upd_pc_i      (upd_pc_i),
        .upd_imm_i     (upd_imm_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_o  (upd_target_o),
        .flush_i       (flush_i),
        .flush_busy_o  (flush_busy_o)
    );

    always #5 clk = ~clk;

    // Monitor: drains every pending expectation against the live outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                S_HIT:   act = {31'd0, pred_hit_o};
                S_TKN:   act = {31'd0, pred_taken_o};
                S_TGT:   act = pred_target_o;
                S_BUSY:  act = {31'd0, flush_busy_o};
                S_RDY:   act = {31'd0, upd_ready_o};
                default: act = upd_target_o;
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string n, input int sel, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.sel  = sel;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string n, input logic [31:0] pc,
                        input logic hit, input logic tkn,
                        input logic [31:0] tgt);
        pred_pc_i = pc;
        chk({n, "_hit"}, S_HIT, {31'd0, hit});
        chk({n, "_tkn"}, S_TKN, {31'd0, tkn});
        chk({n, "_tgt"}, S_TGT, tgt);
        step();
    endtask

    task automatic upd(input string n, input logic [31:0] pc,
                       input logic [15:0] imm, input logic tkn,
                       input logic [31:0] tgt);
        upd_valid_i = 1'b1;
        upd_pc_i    = pc;
        upd_imm_i   = imm;
        upd_taken_i = tkn;
        chk({n, "_rdy"}, S_RDY, 32'd1);
        chk({n, "_utgt"}, S_UTGT, tgt);
        step();
        upd_valid_i = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        pred_pc_i   = 32'h0000_3000;
        upd_valid_i = 1'b0;
        upd_pc_i    = '0;
        upd_imm_i   = '0;
        upd_taken_i = 1'b0;
        flush_i     = 1'b0;
        chk("rst_busy", S_BUSY, 32'd0);
        chk("rst_hit", S_HIT, 32'd0);
        step();
        #2 reset_n = 1'b1;
        step();

        // reset state
        chk("post_rst_rdy", S_RDY, 32'd1);
        chk("post_rst_busy", S_BUSY, 32'd0);
        look("t1", 32'h0000_3000, 0, 0, 32'h0);

        // allocate; same-cycle lookup sees old contents
        pred_pc_i = 32'h0000_3000;
        chk("same_cyc_hit", S_HIT, 32'd0);
        upd("alloc", 32'h0000_3000, 16'hFFFE, 1, 32'h0000_2FFC);
        look("t2", 32'h0000_3000, 1, 1, 32'h0000_2FFC);

        // counter walk: WT -> WNT -> SNT -> SNT -> WNT -> WT -> ST -> ST -> WT
        upd("nt1", 32'h0000_3000, 16'hFFFE, 0, 32'h0000_2FFC);
        look("c_wnt", 32'h0000_3000, 1, 0, 32'h0000_2FFC);
        upd("nt2", 32'h0000_3000, 16'hFFFE, 0, 32'h0000_2FFC);
        upd("nt3", 32'h0000_3000, 16'hFFFE, 0, 32'h0000_2FFC);
        look("c_snt", 32'h0000_3000, 1, 0, 32'h0000_2FFC);
        upd("t1u", 32'h0000_3000, 16'hFFFE, 1, 32'h0000_2FFC);
        look("c_wnt2", 32'h0000_3000, 1, 0, 32'h0000_2FFC);
        upd("t2u", 32'h0000_3000, 16'hFFFE, 1, 32'h0000_2FFC);
        look("c_wt", 32'h0000_3000, 1, 1, 32'h0000_2FFC);
        upd("t3u", 32'h0000_3000, 16'hFFFE, 1, 32'h0000_2FFC);
        upd("t4u", 32'h0000_3000, 16'hFFFE, 1, 32'h0000_2FFC);
        upd("nt4", 32'h0000_3000, 16'hFFFE, 0, 32'h0000_2FFC);
        look("c_st_sat", 32'h0000_3000, 1, 1, 32'h0000_2FFC);

        // taken hit rewrites the target
        upd("retgt", 32'h0000_3000, 16'h0010, 1, 32'h0000_3044);
        look("c_retgt", 32'h0000_3000, 1, 1, 32'h0000_3044);

        // alias on index 0
        upd("alias", 32'h0001_3000, 16'h0001, 1, 32'h0001_3008);
        look("al_old", 32'h0000_3000, 0, 0, 32'h0);
        look("al_new", 32'h0001_3000, 1, 1, 32'h0001_3008);
        upd("miss_nt", 32'h0000_3000, 16'h0000, 0, 32'h0000_3004);
        look("al_nt_old", 32'h0000_3000, 0, 0, 32'h0);
        look("al_nt_new", 32'h0001_3000, 1, 1, 32'h0001_3008);

        // wrap-around target
        upd("wrap", 32'hFFFF_FFF0, 16'h0007, 1, 32'h0000_0010);
        upd("idx1", 32'h0000_3004, 16'h0000, 1, 32'h0000_3008);
        look("idx1_hit", 32'h0000_3004, 1, 1, 32'h0000_3008);

        // flush beats a same-cycle update
        flush_i     = 1'b1;
        upd_valid_i = 1'b1;
        upd_pc_i    = 32'h0000_3008;
        upd_imm_i   = 16'h0000;
        upd_taken_i = 1'b1;
        chk("fl_rdy", S_RDY, 32'd0);
        step();
        flush_i     = 1'b0;
        upd_valid_i = 1'b0;
        pred_pc_i   = 32'h0000_3004;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fl_busy%0d", i), S_BUSY, 32'd1);
            chk($sformatf("fl_hit%0d", i), S_HIT, 32'd0);
            chk($sformatf("fl_tgt%0d", i), S_TGT, 32'd0);
            step();
        end
        chk("fl_done", S_BUSY, 32'd0);
        chk("fl_rdy_back", S_RDY, 32'd1);
        look("fl_m0", 32'h0001_3000, 0, 0, 32'h0);
        look("fl_m1", 32'h0000_3004, 0, 0, 32'h0);
        look("fl_m2", 32'h0000_3008, 0, 0, 32'h0);
        look("fl_m3", 32'hFFFF_FFF0, 0, 0, 32'h0);

        // restart sweep during its 5th cycle
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i == 4) flush_i = 1'b1;
            chk($sformatf("rf_busy%0d", i), S_BUSY, 32'd1);
            step();
            flush_i = 1'b0;
        end
        chk("rf_done", S_BUSY, 32'd0);
        step();

        // async reset mid-sweep
        upd("pre_rst", 32'h0000_303C, 16'h0000, 1, 32'h0000_3040);
        look("pre_rst_hit", 32'h0000_303C, 1, 1, 32'h0000_3040);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        step();
        step();
        #2 reset_n = 1'b0;
        chk("ar_busy", S_BUSY, 32'd0);
        chk("ar_rdy", S_RDY, 32'd1);
        chk("ar_hit", S_HIT, 32'd0);
        #3 reset_n = 1'b1;
        step();
        chk("ar_rdy2", S_RDY, 32'd1);
        chk("ar_busy2", S_BUSY, 32'd0);
        look("ar_m15", 32'h0000_303C, 0, 0, 32'h0);

        step();
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
